// File: rtl/axis_sample_source_pkg.sv
// Shared ECG filter-chain constants and the sample type.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Package axis_ecg_pkg: sample width, FIR output width and normalisation
// shift used by the source and by the filter wrappers downstream.
package axis_ecg_pkg;
    localparam int ECG_SAMPLE_W   = 32;
    localparam int FIR_OUT_W      = 52;
    localparam int FIR_NORM_SHIFT = 20;

    typedef logic signed [ECG_SAMPLE_W-1:0] sample_t;

    // Pointer width for a circular buffer; never zero so DEPTH=1 still elaborates.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/axis_sample_source_if.sv
// AXI-Stream link carrying ECG samples from the source to the filter.
// Latency: n/a (wires only).
// Backpressure: tready from slave to master.
//
// Signals: tvalid/tdata (+ tlast when AXIS_TLAST_EN is defined) master->slave,
// tready slave->master. Modports: master (source side), slave (filter side).
interface axis_sample_source_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
`ifdef AXIS_TLAST_EN
    logic              tlast;
`endif

    modport master (
        input  tready,
        output tvalid,
        output tdata
`ifdef AXIS_TLAST_EN
        , output tlast
`endif
    );

    modport slave (
        output tready,
        input  tvalid,
        input  tdata
`ifdef AXIS_TLAST_EN
        , input  tlast
`endif
    );
endinterface

// File: rtl/axis_sample_source_fifo.sv
// Plain synchronous circular buffer with push/pop, occupancy count and flags.
// Latency: pushed entry visible at head one edge after the push.
// Backpressure: none internally; caller must not push when full or pop when empty.
//
// Ports: clk, rst_n, push/push_dat, pop, head_dat (combinational read of the
// oldest entry), count, full, empty. DEPTH must be a power of two so the
// pointers wrap naturally; count tells full from empty.
module sample_fifo
    import axis_ecg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/axis_sample_source.sv
// AXIS master that buffers front-end sample strobes and feeds the FIR slave.
// Latency: 1 cycle strobe-to-tvalid when empty; 1 sample/clock sustained.
// Backpressure: holds tvalid/tdata on tready=0; drops new samples when full and sets overflow.
//
// Ports: clk, rst_n, sample_valid/sample_data (strobe in), ovf_clear,
// m_axis (master modport: tvalid/tready/tdata[/tlast]), overflow (sticky),
// fill_level (entries held including the output register).
// Macro AXIS_TLAST_EN adds tlast, tagging every FRAME_LEN-th accepted sample.
module axis_sample_source
    import axis_ecg_pkg::*;
#(
    parameter int DATA_W    = ECG_SAMPLE_W,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic signed [DATA_W-1:0]   sample_data,
    input  logic                       ovf_clear,
    axis_sample_source_if.master       m_axis,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);
    localparam int CW = $clog2(DEPTH + 1);
`ifdef AXIS_TLAST_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axis_sample_source: DEPTH must be a power of two in 2..256");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame
        $error("axis_sample_source: FRAME_LEN must be at least 1");
    end

    logic [CW-1:0] fill_q;
    logic          ovf_q;
    logic          out_vld;
    logic [EW-1:0] out_ent;
    logic [EW-1:0] in_ent;
    logic [EW-1:0] head_ent;

    logic          xfer, full, accept, drop;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          load_out, load_sel_fifo;

    assign xfer   = out_vld && m_axis.tready;
    assign full   = (fill_q == CW'(DEPTH));
    // A transfer on the same edge frees a slot, so a full block still accepts.
    assign accept = sample_valid && (!full || xfer);
    assign drop   = sample_valid && !accept;

`ifdef AXIS_TLAST_EN
    localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    logic [FCW-1:0] frame_cnt;
    logic           frame_end;

    assign frame_end = (frame_cnt == FCW'(FRAME_LEN - 1));

    // Only accepted samples advance the frame, so drops never shift tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (accept) begin
            frame_cnt <= frame_end ? '0 : frame_cnt + FCW'(1);
        end
    end

    assign in_ent       = {frame_end, sample_data};
    assign m_axis.tlast = out_ent[DATA_W];
`else
    assign in_ent = sample_data;
`endif

    sample_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (in_ent),
        .pop      (fifo_pop),
        .head_dat (head_ent),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The output register is the first slot; the FIFO only holds what queues
    // behind it, so an empty output register implies an empty FIFO.
    always_comb begin
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        load_out      = 1'b0;
        load_sel_fifo = 1'b0;
        if (!out_vld) begin
            load_out = accept;
        end else if (xfer) begin
            if (!fifo_empty) begin
                fifo_pop      = 1'b1;
                load_out      = 1'b1;
                load_sel_fifo = 1'b1;
                fifo_push     = accept;
            end else begin
                load_out = accept;
            end
        end else begin
            fifo_push = accept && !fifo_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_ent <= '0;
        end else if (load_out) begin
            out_vld <= 1'b1;
            out_ent <= load_sel_fifo ? head_ent : in_ent;
        end else if (xfer) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case ({accept, xfer})
                2'b10:   fill_q <= fill_q + CW'(1);
                2'b01:   fill_q <= fill_q - CW'(1);
                default: fill_q <= fill_q;
            endcase
            // A new drop outranks a clear on the same edge.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // fill_level is kept as its own register; it must always equal the two
    // places data can live.
    a_fill_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        fill_q == fifo_count + CW'(out_vld));

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_ent[DATA_W-1:0];
    assign overflow      = ovf_q;
    assign fill_level    = fill_q;
endmodule

// File: tb/tb_axis_sample_source.sv
module tb_axis_sample_source;
    import axis_ecg_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          sample_valid = 1'b0;
    sample_t       sample_data  = '0;
    logic          ovf_clear    = 1'b0;
    logic          overflow;
    logic [CW-1:0] fill_level;

    int n_vec = 0;
    int n_bad = 0;

    axis_sample_source_if #(.DATA_W(ECG_SAMPLE_W)) m_axis ();

    axis_sample_source #(
        .DATA_W    (ECG_SAMPLE_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ovf_clear    (ovf_clear),
        .m_axis       (m_axis),
        .overflow     (overflow),
        .fill_level   (fill_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    sv;
        sample_t d;
        logic    rdy;
        logic    tv;
        sample_t td;
        logic    ovf;
        int      fill;
    } vec_t;

    function automatic vec_t mk(logic sv, sample_t d, logic rdy,
                                logic tv, sample_t td, logic ovf, int fill);
        vec_t v;
        v = '{sv, d, rdy, tv, td, ovf, fill};
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic drive(input logic sv, input sample_t d, input logic rdy, input logic clr);
        sample_valid  = sv;
        sample_data   = d;
        m_axis.tready = rdy;
        ovf_clear     = clr;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        ovf_clear    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        sample_valid  = 1'b0;
        ovf_clear     = 1'b0;
        m_axis.tready = 1'b0;
        @(negedge clk);
        chk("reset_tvalid", m_axis.tvalid, 0);
        chk("reset_tdata", $signed(m_axis.tdata), 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_fill", fill_level, 0);
`ifdef AXIS_TLAST_EN
        chk("reset_tlast", m_axis.tlast, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[$];
        sample_t q[$];
        sample_t exp_d;
        sample_t d;
        logic    m_ovf, r, s, c, xf, ok;
        int      acc, cyc;

        m_axis.tready = 1'b0;
        do_reset();

        // sv, d, rdy | tvalid, tdata, overflow, fill (after the edge)
        tbl.push_back(mk(1, 1234, 1, 1, 1234, 0, 1));
        tbl.push_back(mk(0, 0,    1, 0, 0,    0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0));
        tbl.push_back(mk(1, -10,  0, 1, -10,  0, 1));
        tbl.push_back(mk(1, -9,   0, 1, -10,  0, 2));
        tbl.push_back(mk(1, -8,   0, 1, -10,  0, 3));
        tbl.push_back(mk(1, -7,   0, 1, -10,  0, 4));
        tbl.push_back(mk(1, -6,   0, 1, -10,  0, 5));
        tbl.push_back(mk(0, 0,    0, 1, -10,  0, 5));
        tbl.push_back(mk(0, 0,    1, 1, -9,   0, 4));
        tbl.push_back(mk(0, 0,    1, 1, -8,   0, 3));
        tbl.push_back(mk(0, 0,    1, 1, -7,   0, 2));
        tbl.push_back(mk(0, 0,    1, 1, -6,   0, 1));
        tbl.push_back(mk(0, 0,    1, 0, 0,    0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].d, tbl[i].rdy, 1'b0);
            chk($sformatf("vec%0d_tvalid", i), m_axis.tvalid, tbl[i].tv);
            if (tbl[i].tv) chk($sformatf("vec%0d_tdata", i), $signed(m_axis.tdata), tbl[i].td);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
            chk($sformatf("vec%0d_fill", i), fill_level, tbl[i].fill);
        end

        // Overfill: 19 strobes into 16 slots, 17..19 lost.
        for (int i = 1; i <= 19; i++) drive(1'b1, sample_t'(i), 1'b0, 1'b0);
        chk("ovf_fill", fill_level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", $signed(m_axis.tdata), 1);
        drive(1'b1, 77, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_set_wins_fill", fill_level, 16);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_cleared", overflow, 0);

        // Full + strobe + transfer on the same edge: accepted, no overflow.
        drive(1'b1, 99, 1'b1, 1'b0);
        chk("full_xfer_overflow", overflow, 0);
        chk("full_xfer_fill", fill_level, 16);
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? sample_t'(k + 2) : sample_t'(99);
            chk($sformatf("drain%0d_tvalid", k), m_axis.tvalid, 1);
            chk($sformatf("drain%0d_tdata", k), $signed(m_axis.tdata), exp_d);
            drive(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drain_tvalid", m_axis.tvalid, 0);
        chk("drain_fill", fill_level, 0);

        // Random traffic against a queue scoreboard; head must match every cycle.
        m_ovf = 1'b0;
        acc   = 0;
        cyc   = 0;
        while (acc < 10000 && cyc < 60000) begin
            cyc++;
            ok = (m_axis.tvalid === (q.size() != 0)) && (fill_level === CW'(q.size()))
                 && (overflow === m_ovf);
            if (q.size() != 0 && m_axis.tdata !== q[0]) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rand cycle %0d: tvalid=%b fill=%0d ovf=%b tdata=%0d, expected tvalid=%b fill=%0d ovf=%b head=%0d",
                         cyc, m_axis.tvalid, fill_level, overflow, $signed(m_axis.tdata),
                         q.size() != 0, q.size(), m_ovf, (q.size() != 0) ? q[0] : sample_t'(0));
                break;
            end
            r  = ($urandom_range(0, 99) < 60);
            s  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 99) == 0);
            d  = sample_t'($urandom);
            xf = (q.size() != 0) && r;
            if (xf) void'(q.pop_front());
            if (s && (q.size() < DEPTH)) begin
                q.push_back(d);
                acc++;
            end else if (s) begin
                m_ovf = 1'b1;
            end
            if (!(s && !(q.size() <= DEPTH && q[$] == d)) && c && !(s && q.size() == DEPTH && q[$] != d))
                m_ovf = m_ovf;
            if (c && !(s && (q.size() == 0 || q[$] != d))) m_ovf = 1'b0;
            drive(s, d, r, c);
        end
        chk("rand_samples", acc, 10000);

        // Reset mid-stall drops everything at once and replays nothing.
        m_axis.tready = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, sample_t'(500 + i), 1'b0, 1'b0);
        chk("stall_tvalid", m_axis.tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", m_axis.tvalid, 0);
        chk("async_rst_fill", fill_level, 0);
        chk("async_rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_tvalid", m_axis.tvalid, 0);
        chk("post_rst_fill", fill_level, 0);

`ifdef AXIS_TLAST_EN
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, sample_t'(k + 1), 1'b1, 1'b0);
            chk($sformatf("frame%0d_tdata", k), $signed(m_axis.tdata), k + 1);
            chk($sformatf("frame%0d_tlast", k), m_axis.tlast, (k % 4) == 3);
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("frame_idle", m_axis.tvalid, 0);
        for (int k = 0; k < 16; k++) drive(1'b1, sample_t'(200 + k), 1'b0, 1'b0);
        drive(1'b1, 999, 1'b0, 1'b0);
        chk("frame_drop_ovf", overflow, 1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fdrain%0d_tdata", k), $signed(m_axis.tdata), 200 + k);
            chk($sformatf("fdrain%0d_tlast", k), m_axis.tlast, (k % 4) == 3);
            drive(1'b0, 0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, sample_t'(300 + k), 1'b1, 1'b0);
            chk($sformatf("fpost%0d_tdata", k), $signed(m_axis.tdata), 300 + k);
            chk($sformatf("fpost%0d_tlast", k), m_axis.tlast, k == 3);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
